// File: rtl/led_pkg.sv
// Shared types and helpers for the LED fade/PWM output stage.
package led_pkg;

  // Per-channel fade state: dark, ramping up, fully lit, ramping down.
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

  // Highest brightness level / PWM count for a given PWM resolution.
  function automatic int unsigned pwm_max(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM with brightness level plus the registered PWM compare.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                fade_step_i,
  input  logic                pattern_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                busy_o
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic [PWM_BITS-1:0] lvl_up, lvl_dn;
  logic                led_q, led_d;

  // Saturating one-level neighbours of the current brightness.
  assign lvl_up = (lvl_q == LVL_MAX) ? LVL_MAX : lvl_q + LVL_ONE;
  assign lvl_dn = (lvl_q == '0) ? '0 : lvl_q - LVL_ONE;

  // Next state/level, only moving on a fade step; landing on an end level settles the state.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (fade_step_i) begin
      case (state_q)
        OFF: begin
          if (pattern_i) begin
            lvl_d   = LVL_ONE;
            state_d = (LVL_ONE == LVL_MAX) ? ON : RISE;
          end
        end
        ON: begin
          if (!pattern_i) begin
            lvl_d   = LVL_MAX - LVL_ONE;
            state_d = ((LVL_MAX - LVL_ONE) == '0) ? OFF : FALL;
          end
        end
        RISE, FALL: begin
          // Direction follows the pattern bit, so a reversal continues from the current level.
          if (pattern_i) begin
            lvl_d   = lvl_up;
            state_d = (lvl_up == LVL_MAX) ? ON : RISE;
          end else begin
            lvl_d   = lvl_dn;
            state_d = (lvl_dn == '0) ? OFF : FALL;
          end
        end
        default: begin
          state_d = OFF;
          lvl_d   = '0;
        end
      endcase
    end
  end

  // PWM compare: full level is solid on, otherwise high while the counter is below the level.
  assign led_d  = EN && ((lvl_q == LVL_MAX) || (pwm_cnt_i < lvl_q));
  assign led_o  = led_q;
  assign busy_o = (state_q == RISE) || (state_q == FALL);

  // Channel state, level and output register; reset blanks the pin immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= OFF;
      lvl_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: shared PWM timebase and fade pacing driving one fade channel per LED.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned PRESCALE     = 16,
  parameter int unsigned FADE_PERIODS = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] PATTERN,
  output logic [WIDTH-1:0] LED_OUT,
  output logic             BUSY,
  output logic             PERIOD_START
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FD_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0]     FD_LAST = FD_W'(FADE_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [FD_W-1:0]     fdiv_q, fdiv_d;
  logic                period_start_q;
  logic                busy_q;
  logic                tick, bnd, fstep;
  logic [WIDTH-1:0]    ch_busy;

  // tick: one PWM step; bnd: last step of a PWM period; fstep: one brightness step.
  assign tick  = EN && (presc_q == PS_LAST);
  assign bnd   = tick && (cnt_q == CNT_MAX);
  assign fstep = bnd && (fdiv_q == FD_LAST);

  // Timebase next-state: everything parks at zero while disabled; the PWM counter wraps naturally.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    fdiv_d  = fdiv_q;
    if (!EN) begin
      presc_d = '0;
      cnt_d   = '0;
      fdiv_d  = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
      if (tick) begin
        cnt_d = cnt_q + PWM_BITS'(1);
      end
      if (bnd) begin
        fdiv_d = (fdiv_q == FD_LAST) ? '0 : fdiv_q + FD_W'(1);
      end
    end
  end

  // Timebase, period marker and aggregate busy registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      fdiv_q         <= '0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      fdiv_q         <= fdiv_d;
      period_start_q <= bnd;
      busy_q         <= |ch_busy;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS(PWM_BITS)
      ) u_ch (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .fade_step_i(fstep),
        .pattern_i  (PATTERN[gi]),
        .pwm_cnt_i  (cnt_q),
        .led_o      (LED_OUT[gi]),
        .busy_o     (ch_busy[gi])
      );
    end
  endgenerate

  assign BUSY         = busy_q;
  assign PERIOD_START = period_start_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with a cycle-level reference model and scoreboard.
module tb_led_fade_pwm;

  localparam int W    = 8;
  localparam int PB   = 4;
  localparam int PRE  = 2;
  localparam int FP   = 1;
  localparam int MAXL = 15;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         EN = 1'b0;
  logic [W-1:0] PATTERN = '0;
  logic [W-1:0] LED_OUT;
  logic         BUSY;
  logic         PERIOD_START;

  led_fade_pwm #(
    .WIDTH(W), .PWM_BITS(PB), .PRESCALE(PRE), .FADE_PERIODS(FP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PATTERN(PATTERN),
    .LED_OUT(LED_OUT), .BUSY(BUSY), .PERIOD_START(PERIOD_START)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] led;
    logic         busy;
    logic         ps;
  } exp_t;

  typedef struct {
    logic         en;
    logic [W-1:0] pat;
    int           cyc;
    logic [W-1:0] led;
    logic         busy;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: brightness seeks the pattern target one level per fade step.
  int m_presc, m_cnt, m_fdiv;
  int m_lvl[W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    m_cnt   = 0;
    m_fdiv  = 0;
    for (int i = 0; i < W; i++) m_lvl[i] = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs currently applied.
  task automatic model_step();
    bit   tk, b, f;
    exp_t e;
    tk = EN && (m_presc == PRE - 1);
    b  = tk && (m_cnt == MAXL);
    f  = b && (m_fdiv == FP - 1);
    e.busy = 1'b0;
    for (int i = 0; i < W; i++) begin
      e.led[i] = EN && ((m_lvl[i] == MAXL) || (m_cnt < m_lvl[i]));
      if (m_lvl[i] > 0 && m_lvl[i] < MAXL) e.busy = 1'b1;
    end
    e.ps = b;
    if (f) begin
      for (int i = 0; i < W; i++) begin
        if (PATTERN[i] && m_lvl[i] < MAXL) m_lvl[i]++;
        else if (!PATTERN[i] && m_lvl[i] > 0) m_lvl[i]--;
      end
    end
    if (!EN) begin
      m_presc = 0;
      m_cnt   = 0;
      m_fdiv  = 0;
    end else begin
      m_presc = (m_presc + 1) % PRE;
      if (tk) m_cnt = (m_cnt + 1) % (MAXL + 1);
      if (b) m_fdiv = (m_fdiv + 1) % FP;
    end
    sb_q.push_back(e);
  endtask

  // Advance n clocks, checking every registered output against the scoreboard.
  task automatic step(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      chk("sb_led", LED_OUT, e.led);
      chk("sb_busy", BUSY, e.busy);
      chk("sb_period_start", PERIOD_START, e.ps);
    end
  endtask

  // Assert reset, check outputs clear without a clock, release mid-cycle.
  task automatic do_reset();
    RST_N   = 1'b0;
    EN      = 1'b0;
    PATTERN = '0;
    #1;
    chk("rst_led", LED_OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_period_start", PERIOD_START, 0);
    model_reset();
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  // Count cycles (over n clocks) in which LED_OUT[b] is high; also note first high and stray bits.
  task automatic count_high(input int b, input int n, output int cnt, output int first, output int stray);
    cnt   = 0;
    first = -1;
    stray = 0;
    for (int k = 1; k <= n; k++) begin
      step(1);
      if (LED_OUT[b]) begin
        cnt++;
        if (first < 0) first = k;
      end
      for (int i = 0; i < W; i++) if (i != b && LED_OUT[i]) stray++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   first_ps, cnt, first, stray, bad;

    vecs[0] = '{1'b1, 8'hFF, 520, 8'hFF, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 520, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 520, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 8'h5A, 40,  8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 36,  8'hA5, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 600, 8'h00, 1'b0};

    #1;
    do_reset();

    // Table of steady-state and early-ramp vectors.
    for (int v = 0; v < 6; v++) begin
      EN      = vecs[v].en;
      PATTERN = vecs[v].pat;
      step(vecs[v].cyc);
      chk($sformatf("vec%0d_led", v), LED_OUT, vecs[v].led);
      chk($sformatf("vec%0d_busy", v), BUSY, vecs[v].busy);
      $display("vec %0d: en=%0b pat=%02h cycles=%0d led=%02h busy=%0b", v, vecs[v].en,
               vecs[v].pat, vecs[v].cyc, LED_OUT, BUSY);
    end

    // Full ramp up from reset: first period marker, busy window, solid-on result.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'hFF;
    first_ps = 0;
    for (int k = 1; k <= 40 && first_ps == 0; k++) begin
      step(1);
      if (PERIOD_START) first_ps = k + 1;
    end
    chk("first_period_start_cycle", first_ps, 33);
    chk("busy_before_first_step", BUSY, 0);
    step(1);
    chk("busy_after_first_step", BUSY, 1);
    step(447);
    chk("busy_before_full", BUSY, 1);
    step(1);
    chk("busy_after_full", BUSY, 0);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (LED_OUT !== 8'hFF || BUSY !== 1'b0) bad++;
    end
    chk("full_on_period", bad, 0);
    $display("ramp: first period_start cycle %0d, full-on bad cycles %0d", first_ps, bad);

    // Duty at level 4: 8 of 32 cycles, starting one cycle after the period begins.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'h01;
    step(128);
    PATTERN = 8'h00;
    count_high(0, 32, cnt, first, stray);
    chk("duty_lvl4_high", cnt, 8);
    chk("duty_lvl4_first", first, 1);
    chk("duty_other_bits", stray, 0);
    $display("duty: high=%0d first=%0d stray=%0d", cnt, first, stray);

    // Glitch on the pattern between fade steps is ignored.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'h01;
    step(500);
    bad = 0;
    PATTERN = 8'h00;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) PATTERN = 8'h01;
      step(1);
      if (LED_OUT[0] !== 1'b1 || BUSY !== 1'b0) bad++;
    end
    chk("glitch_rejected", bad, 0);
    $display("glitch: bad cycles %0d", bad);

    // Reversal mid-ramp at level 7: drops to 6, then reaches OFF six steps later.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'h80;
    step(224);
    PATTERN = 8'h00;
    step(32);
    count_high(7, 32, cnt, first, stray);
    chk("reversal_lvl6_high", cnt, 12);
    chk("reversal_busy", BUSY, 1);
    step(159);
    chk("reversal_busy_before_off", BUSY, 1);
    step(2);
    chk("reversal_led7_off", LED_OUT[7], 0);
    chk("reversal_busy_off", BUSY, 0);
    step(32);
    $display("reversal: lvl6 high=%0d led=%02h busy=%0b", cnt, LED_OUT, BUSY);

    // Enable pause at level 9: blanked, silent, then resumes from 9 with the next step 32 cycles on.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'hFF;
    step(300);
    EN = 1'b0;
    step(1);
    chk("pause_led_blank", LED_OUT, 0);
    bad = 0;
    for (int k = 0; k < 49; k++) begin
      step(1);
      if (LED_OUT !== '0 || PERIOD_START !== 1'b0) bad++;
    end
    chk("pause_quiet", bad, 0);
    EN = 1'b1;
    count_high(0, 32, cnt, first, stray);
    chk("resume_lvl9_high", cnt, 18);
    count_high(0, 32, cnt, first, stray);
    chk("resume_lvl10_high", cnt, 20);
    $display("pause: quiet bad=%0d lvl10 high=%0d", bad, cnt);

    // Asynchronous reset mid-fade clears outputs before the next edge; channels restart from OFF.
    do_reset();
    EN = 1'b1;
    PATTERN = 8'hFF;
    step(100);
    chk("pre_reset_led", LED_OUT, 8'hFF);
    chk("pre_reset_busy", BUSY, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_led", LED_OUT, 0);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_period_start", PERIOD_START, 0);
    model_reset();
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    step(32);
    count_high(0, 32, cnt, first, stray);
    chk("restart_lvl1_high", cnt, 2);
    chk("restart_busy", BUSY, 1);
    $display("async reset: restart lvl1 high=%0d busy=%0b", cnt, BUSY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
